stage_sequencer: RTL
====================

Name: stage_sequencer

Overview:
- Parametrised multicycle CPU stage controller; successor to the two-state FETCH/DECODE toggler.
- Sequences FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, with a configurable stage count, stall hold, memory-stage skip, halt, and a retired-instruction counter.
- Sits at the top of the multicycle core and drives the per-stage enables of the datapath.

Parameters:
- NUM_STAGES, 5, active stages; legal values 2..5.
  - 2: F,D
  - 3: F,D,E
  - 4: F,D,E,W
  - 5: F,D,E,M,W
- CNT_W, 32, width of the retired-instruction counter (and of the stall counter when compiled in).

Ports:
- r_clk  in  1  clock
- r_rst  in  1  reset; asynchronous, active-high
- i_en  in  1  run enable; low freezes all state
- i_stall  in  1  hold the current stage this cycle
- i_skip_mem  in  1  instruction has no memory access; sampled only in EXECUTE
- i_halt  in  1  request halt after the current instruction
- o_stage  out  3  current stage, encoded as stage_t
- o_stage_oh  out  5  one-hot of o_stage; bit index = stage_t value; all zero when HALTED
- o_retire  out  1  combinational pulse: the last stage completes this cycle
- o_instret  out  CNT_W  count of retired instructions
- o_halted  out  1  high while in HALTED

Behaviour:
- Reset (async, r_rst=1): o_stage=FETCH, o_instret=0, halt_pend=0, o_halted=0, o_retire=0.
- advance = i_en & ~i_stall & (stage!=HALTED).
- On r_clk rising with advance:
  - FETCH -> DECODE.
  - DECODE -> EXECUTE, or -> FETCH if NUM_STAGES=2.
  - EXECUTE -> MEMORY if NUM_STAGES=5 and i_skip_mem=0.
  - EXECUTE -> WRITEBACK if (NUM_STAGES=5 and i_skip_mem=1) or NUM_STAGES=4.
  - EXECUTE -> FETCH if NUM_STAGES=3.
  - MEMORY -> WRITEBACK.
  - WRITEBACK -> FETCH.
- Last stage: DECODE/EXECUTE/WRITEBACK for N=2/3/≥4.
- o_retire = advance & (stage==last stage). On that edge o_instret increments, wrapping from 2^CNT_W-1 to 0.
- Stall: i_stall has priority over advance. Stage is held, o_retire=0, counter unchanged.
- i_en=0: everything frozen, including halt_pend capture.
- Halt request:
  - halt_pend is set on any edge where i_en & i_halt, and cleared only by reset.
  - On a retire edge with halt_pend | i_halt, next stage is HALTED (not FETCH); that retire still counts.
  - HALTED is terminal until reset; o_halted=1, o_stage=HALTED.
- Reset mid-instruction: immediate return to FETCH; the partial instruction is not counted.
- Unused stage encodings are unreachable. Any illegal stage value recovers to FETCH on the next edge.
- Out-of-range NUM_STAGES: elaboration-time $error.

Optional Feature:
- Macro: STAGE_SEQ_STALL_CNT_EN.
- Defined:
  - Adds output o_stall_cycles, width CNT_W, reset 0.
  - Increments on every edge where i_en & i_stall & stage!=HALTED; wraps.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package stage_seq_pkg:
  - typedef enum logic [2:0] stage_t: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALTED=7.
  - Constant STAGE_W=3.
  - Function last_stage(n) returning stage_t.
- One sub-module, wrap_counter (parameter W; ports r_clk, r_rst, inc, q). Instantiated for o_instret and, when enabled, o_stall_cycles.

Test Plan:
- NUM_STAGES=2, i_en=1, 6 cycles after reset -> o_stage alternates FETCH,DECODE,FETCH...; o_instret=3.
- NUM_STAGES=5, i_skip_mem=0 on the first instruction, 1 on the second -> sequences F,D,E,M,W then F,D,E,W; o_instret=2 after 9 advancing cycles.
- NUM_STAGES=5, i_stall=1 for 3 cycles in EXECUTE -> o_stage stays EXECUTE for 4 cycles; o_retire never high during the stall; o_stall_cycles=3 with macro defined.
- i_halt pulsed for 1 cycle during DECODE (N=4) -> instruction completes to WRITEBACK, o_instret+1, then HALTED, o_halted=1, o_stage_oh=0; further cycles change nothing.
- CNT_W=4, 16 instructions at N=3 -> o_instret wraps to 0; r_rst asserted mid-EXECUTE between clock edges -> o_stage=FETCH and o_instret=0 immediately, before the next edge.
- i_en=0 for 5 cycles in MEMORY with i_halt=1 -> no state, counter or halt_pend change; after i_en=1 the instruction retires and the sequencer goes to FETCH.

Source files
------------

// File: rtl/stage_seq_pkg.sv
// Shared stage encoding and helpers for the multicycle stage sequencer.
package stage_seq_pkg;

  localparam int STAGE_W = 3;

  typedef enum logic [STAGE_W-1:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    HALTED    = 3'd7
  } stage_t;

  function automatic stage_t last_stage(input int n);
    if (n == 2)
      return DECODE;
    else if (n == 3)
      return EXECUTE;
    else
      return WRITEBACK;
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Free-running up counter with enable; wraps modulo 2^W.
module wrap_counter #(
  parameter int W = 32
) (
  input  logic         r_clk,
  input  logic         r_rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] ONE = 1;

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst)
      q <= '0;
    else if (inc)
      q <= q + ONE;
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multicycle CPU stage controller: F/D/E/M/W sequencing, stall, halt, instret.
// STAGE_SEQ_STALL_CNT_EN adds the o_stall_cycles counter output.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int NUM_STAGES = 5,
  parameter int CNT_W      = 32
) (
  input  logic               r_clk,
  input  logic               r_rst,
  input  logic               i_en,
  input  logic               i_stall,
  input  logic               i_skip_mem,
  input  logic               i_halt,
  output logic [STAGE_W-1:0] o_stage,
  output logic [4:0]         o_stage_oh,
  output logic               o_retire,
  output logic [CNT_W-1:0]   o_instret,
  output logic               o_halted
`ifdef STAGE_SEQ_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]   o_stall_cycles
`endif
);

  localparam stage_t LAST = last_stage(NUM_STAGES);

  if (NUM_STAGES < 2 || NUM_STAGES > 5) begin : g_bad_cfg
    $error("stage_sequencer: NUM_STAGES must be 2..5");
  end

  stage_t stage;
  logic   halt_pend;
  logic   advance;
  logic   retire;
  logic   illegal;

  assign illegal = (stage == stage_t'(3'd5)) ||
                   (stage == stage_t'(3'd6));
  assign advance = i_en && !i_stall && (stage != HALTED);
  assign retire  = advance && (stage == LAST);

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      stage     <= FETCH;
      halt_pend <= 1'b0;
    end else begin
      if (i_en && i_halt)
        halt_pend <= 1'b1;
      if (illegal)
        stage <= FETCH;
      else if (retire)
        stage <= (halt_pend || i_halt) ? HALTED : FETCH;
      else if (advance) begin
        // Last-stage exits are handled by the retire branch above.
        case (stage)
          FETCH:     stage <= DECODE;
          DECODE:    stage <= EXECUTE;
          EXECUTE:   stage <= (NUM_STAGES == 5 && !i_skip_mem)
                              ? MEMORY : WRITEBACK;
          MEMORY:    stage <= WRITEBACK;
          default:   stage <= FETCH;
        endcase
      end
    end
  end

  assign o_stage  = stage;
  assign o_retire = retire;
  assign o_halted = (stage == HALTED);

  always_comb begin
    o_stage_oh = '0;
    if (!illegal && stage != HALTED)
      o_stage_oh = 5'b00001 << stage;
  end

  wrap_counter #(
    .W (CNT_W)
  ) u_instret (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .inc   (retire),
    .q     (o_instret)
  );

`ifdef STAGE_SEQ_STALL_CNT_EN
  wrap_counter #(
    .W (CNT_W)
  ) u_stall_cnt (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .inc   (i_en && i_stall && (stage != HALTED)),
    .q     (o_stall_cycles)
  );
`endif

endmodule
